// File: rtl/cond_logic.sv
// cond_logic: conditional-execution stage behind the single-cycle ALU.
// Holds the architectural NZCV register, evaluates the ARM condition field
// against it, gates the decoder strobes and keeps saturating debug counters
// of executed and squashed instructions.
// Optional feature: define COND_STICKY_Q_EN to build a sticky overflow flag
// (q_flag output, clr_q input). Without the macro neither port exists.
module cond_logic #(
    parameter logic [3:0] FLAG_RESET = 4'b0000,
    parameter int         CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [3:0]       cond,
    input  logic [3:0]       alu_flags,
    input  logic [1:0]       flag_w,
    input  logic             pcs,
    input  logic             reg_w,
    input  logic             mem_w,
    input  logic             no_write,
    input  logic             cnt_clr,
`ifdef COND_STICKY_Q_EN
    input  logic             clr_q,
    output logic             q_flag,
`endif
    output logic [3:0]       flags,
    output logic             cond_ex,
    output logic             pc_src,
    output logic             reg_write,
    output logic             mem_write,
    output logic [CNT_W-1:0] exec_cnt,
    output logic [CNT_W-1:0] skip_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    // Evaluate an ARM condition code against a stored {N,Z,C,V} value.
    function automatic logic cond_eval(input logic [3:0] cc, input logic [3:0] nzcv);
        logic n, z, c, v;
        logic res;
        n = nzcv[3];
        z = nzcv[2];
        c = nzcv[1];
        v = nzcv[0];
        case (cc)
            4'b0000: res = z;
            4'b0001: res = ~z;
            4'b0010: res = c;
            4'b0011: res = ~c;
            4'b0100: res = n;
            4'b0101: res = ~n;
            4'b0110: res = v;
            4'b0111: res = ~v;
            4'b1000: res = c & ~z;
            4'b1001: res = ~c | z;
            4'b1010: res = (n == v);
            4'b1011: res = (n != v);
            4'b1100: res = ~z & (n == v);
            4'b1101: res = z | (n != v);
            4'b1110: res = 1'b1;
            4'b1111: res = 1'b0;
            default: res = 1'b0;
        endcase
        return res;
    endfunction

    // Saturating increment: an all-ones counter stays at all-ones.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val);
        logic [CNT_W-1:0] res;
        if (val == CNT_MAX) begin
            res = val;
        end else begin
            res = val + CNT_ONE;
        end
        return res;
    endfunction

    logic [3:0]       flags_q,    flags_d;
    logic [CNT_W-1:0] exec_cnt_q, exec_cnt_d;
    logic [CNT_W-1:0] skip_cnt_q, skip_cnt_d;
    logic             cond_ex_s;
    logic             commit_s;

    // Condition decode from the registered flags only (no ALU bypass) and strobe gating.
    always_comb begin
        cond_ex_s = cond_eval(cond, flags_q);
        commit_s  = en & cond_ex_s;
        cond_ex   = cond_ex_s;
        pc_src    = commit_s & pcs;
        reg_write = commit_s & reg_w & ~no_write;
        mem_write = commit_s & mem_w;
    end

    // Next NZCV: each group loads independently, only for an executed instruction.
    always_comb begin
        flags_d = flags_q;
        if (commit_s) begin
            if (flag_w[1]) begin
                flags_d[3:2] = alu_flags[3:2];
            end else begin
                flags_d[3:2] = flags_q[3:2];
            end
            if (flag_w[0]) begin
                flags_d[1:0] = alu_flags[1:0];
            end else begin
                flags_d[1:0] = flags_q[1:0];
            end
        end else begin
            flags_d = flags_q;
        end
    end

    // Next counter values: clear wins, otherwise count executed or squashed.
    always_comb begin
        exec_cnt_d = exec_cnt_q;
        skip_cnt_d = skip_cnt_q;
        if (cnt_clr) begin
            exec_cnt_d = CNT_ZERO;
            skip_cnt_d = CNT_ZERO;
        end else if (en) begin
            if (cond_ex_s) begin
                exec_cnt_d = sat_inc(exec_cnt_q);
            end else begin
                skip_cnt_d = sat_inc(skip_cnt_q);
            end
        end else begin
            exec_cnt_d = exec_cnt_q;
            skip_cnt_d = skip_cnt_q;
        end
    end

    // Architectural flag and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q    <= FLAG_RESET;
            exec_cnt_q <= CNT_ZERO;
            skip_cnt_q <= CNT_ZERO;
        end else begin
            flags_q    <= flags_d;
            exec_cnt_q <= exec_cnt_d;
            skip_cnt_q <= skip_cnt_d;
        end
    end

    assign flags    = flags_q;
    assign exec_cnt = exec_cnt_q;
    assign skip_cnt = skip_cnt_q;

`ifdef COND_STICKY_Q_EN
    logic q_flag_q, q_flag_d;

    // Sticky overflow: a new overflow beats a same-cycle clear.
    always_comb begin
        q_flag_d = q_flag_q;
        if (commit_s & flag_w[0] & alu_flags[0]) begin
            q_flag_d = 1'b1;
        end else if (clr_q) begin
            q_flag_d = 1'b0;
        end else begin
            q_flag_d = q_flag_q;
        end
    end

    // Sticky overflow register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_flag_q <= 1'b0;
        end else begin
            q_flag_q <= q_flag_d;
        end
    end

    assign q_flag = q_flag_q;
`endif

endmodule

// File: tb/tb_cond_logic.sv
// Self-checking bench for cond_logic (CNT_W = 4 so saturation is reachable).
// Table-driven vectors feed a scoreboard queue; multi-cycle corners are
// hand-written sequences. Sticky-Q checks build only with COND_STICKY_Q_EN.
module tb_cond_logic;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en;
    logic [3:0]    cond;
    logic [3:0]    alu_flags;
    logic [1:0]    flag_w;
    logic          pcs, reg_w, mem_w, no_write, cnt_clr;
    logic          clr_q;
    logic          q_flag;
    logic [3:0]    flags;
    logic          cond_ex, pc_src, reg_write, mem_write;
    logic [CW-1:0] exec_cnt, skip_cnt;

    int n_vec = 0;
    int n_err = 0;

    cond_logic #(.FLAG_RESET(4'b0000), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .cond      (cond),
        .alu_flags (alu_flags),
        .flag_w    (flag_w),
        .pcs       (pcs),
        .reg_w     (reg_w),
        .mem_w     (mem_w),
        .no_write  (no_write),
        .cnt_clr   (cnt_clr),
`ifdef COND_STICKY_Q_EN
        .clr_q     (clr_q),
        .q_flag    (q_flag),
`endif
        .flags     (flags),
        .cond_ex   (cond_ex),
        .pc_src    (pc_src),
        .reg_write (reg_write),
        .mem_write (mem_write),
        .exec_cnt  (exec_cnt),
        .skip_cnt  (skip_cnt)
    );

`ifndef COND_STICKY_Q_EN
    assign q_flag = 1'b0;
`endif

    always #5 clk = ~clk;

    typedef struct {
        logic          en;
        logic [3:0]    cond;
        logic [3:0]    alu;
        logic [1:0]    fw;
        logic          pcs, rw, mw, nw, clr;
        logic          ex, pc, rwo, mwo;
        logic [3:0]    fl;
        logic [CW-1:0] ec, sc;
    } vec_t;

    vec_t tbl[$];
    vec_t exp_q[$];

    function automatic vec_t mk(
        input logic en_v, input logic [3:0] c, input logic [3:0] a, input logic [1:0] w,
        input logic p, input logic r, input logic m, input logic n, input logic cl,
        input logic ex, input logic pc, input logic ro, input logic mo,
        input logic [3:0] fl, input int ec, input int sc);
        vec_t v;
        v.en = en_v; v.cond = c; v.alu = a; v.fw = w;
        v.pcs = p; v.rw = r; v.mw = m; v.nw = n; v.clr = cl;
        v.ex = ex; v.pc = pc; v.rwo = ro; v.mwo = mo;
        v.fl = fl; v.ec = CW'(ec); v.sc = CW'(sc);
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic drive_idle();
        en = 1'b0; cond = 4'b1110; alu_flags = 4'b0000; flag_w = 2'b00;
        pcs = 1'b0; reg_w = 1'b0; mem_w = 1'b0; no_write = 1'b0; cnt_clr = 1'b0; clr_q = 1'b0;
    endtask

    // Drive one vector at the falling edge, check combinational outputs,
    // then check the registered state just after the next rising edge.
    task automatic apply_vec(input vec_t v, input int idx);
        vec_t e;
        @(negedge clk);
        en = v.en; cond = v.cond; alu_flags = v.alu; flag_w = v.fw;
        pcs = v.pcs; reg_w = v.rw; mem_w = v.mw; no_write = v.nw; cnt_clr = v.clr;
        exp_q.push_back(v);
        #1;
        e = exp_q[0];
        check($sformatf("v%0d cond_ex", idx),   {31'd0, cond_ex},   {31'd0, e.ex});
        check($sformatf("v%0d pc_src", idx),    {31'd0, pc_src},    {31'd0, e.pc});
        check($sformatf("v%0d reg_write", idx), {31'd0, reg_write}, {31'd0, e.rwo});
        check($sformatf("v%0d mem_write", idx), {31'd0, mem_write}, {31'd0, e.mwo});
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check($sformatf("v%0d flags", idx),    {28'd0, flags},    {28'd0, e.fl});
        check($sformatf("v%0d exec_cnt", idx), 32'(exec_cnt),     32'(e.ec));
        check($sformatf("v%0d skip_cnt", idx), 32'(skip_cnt),     32'(e.sc));
    endtask

`ifdef COND_STICKY_Q_EN
    task automatic q_step(input logic e_v, input logic [1:0] w, input logic [3:0] a,
                          input logic cq, input logic exp_q_v, input string name);
        @(negedge clk);
        en = e_v; cond = 4'b1110; flag_w = w; alu_flags = a; clr_q = cq; cnt_clr = 1'b0;
        @(posedge clk);
        #1;
        check(name, {31'd0, q_flag}, {31'd0, exp_q_v});
    endtask
`endif

    initial begin
        //                en cond     alu      fw     p  r  m  n  cl   ex pc ro mo  flags    ec sc
        tbl.push_back(mk(1, 4'b0000, 4'b0000, 2'b00, 0, 1, 0, 0, 0,   0, 0, 0, 0, 4'b0000, 0, 1)); // EQ fails from reset
        tbl.push_back(mk(1, 4'b1110, 4'b0100, 2'b11, 0, 0, 0, 0, 0,   1, 0, 0, 0, 4'b0100, 1, 1)); // AL sets Z
        tbl.push_back(mk(1, 4'b0000, 4'b0000, 2'b00, 1, 0, 0, 0, 0,   1, 1, 0, 0, 4'b0100, 2, 1)); // EQ uses stored Z
        tbl.push_back(mk(1, 4'b1110, 4'b1000, 2'b11, 0, 1, 1, 1, 0,   1, 0, 0, 1, 4'b1000, 3, 1)); // no_write
        tbl.push_back(mk(1, 4'b1011, 4'b0000, 2'b00, 0, 1, 0, 0, 0,   1, 0, 1, 0, 4'b1000, 4, 1)); // LT passes
        tbl.push_back(mk(1, 4'b1010, 4'b0011, 2'b11, 0, 0, 1, 0, 0,   0, 0, 0, 0, 4'b1000, 4, 2)); // GE fails, no write
        tbl.push_back(mk(0, 4'b1110, 4'b1111, 2'b11, 1, 1, 1, 0, 0,   1, 0, 0, 0, 4'b1000, 4, 2)); // bubble
        tbl.push_back(mk(1, 4'b1110, 4'b0000, 2'b11, 0, 0, 0, 0, 0,   1, 0, 0, 0, 4'b0000, 5, 2));
        tbl.push_back(mk(1, 4'b1110, 4'b1111, 2'b01, 0, 0, 0, 0, 0,   1, 0, 0, 0, 4'b0011, 6, 2)); // C,V only
        tbl.push_back(mk(1, 4'b1000, 4'b0000, 2'b00, 0, 0, 0, 0, 0,   1, 0, 0, 0, 4'b0011, 7, 2)); // HI
        tbl.push_back(mk(1, 4'b1001, 4'b0000, 2'b00, 0, 0, 0, 0, 0,   0, 0, 0, 0, 4'b0011, 7, 3)); // LS
        tbl.push_back(mk(1, 4'b1110, 4'b0100, 2'b10, 0, 0, 0, 0, 0,   1, 0, 0, 0, 4'b0111, 8, 3)); // N,Z only
        tbl.push_back(mk(1, 4'b1100, 4'b0000, 2'b00, 0, 0, 0, 0, 0,   0, 0, 0, 0, 4'b0111, 8, 4)); // GT
        tbl.push_back(mk(1, 4'b1101, 4'b0000, 2'b00, 0, 0, 0, 0, 0,   1, 0, 0, 0, 4'b0111, 9, 4)); // LE
        tbl.push_back(mk(1, 4'b1111, 4'b0000, 2'b00, 1, 0, 0, 0, 0,   0, 0, 0, 0, 4'b0111, 9, 5)); // NV
        tbl.push_back(mk(1, 4'b0110, 4'b0000, 2'b00, 0, 0, 0, 0, 0,   1, 0, 0, 0, 4'b0111, 10, 5)); // VS
        tbl.push_back(mk(1, 4'b0001, 4'b0000, 2'b00, 0, 0, 0, 0, 0,   0, 0, 0, 0, 4'b0111, 10, 6)); // NE
        tbl.push_back(mk(1, 4'b1110, 4'b0000, 2'b00, 0, 0, 0, 0, 1,   1, 0, 0, 0, 4'b0111, 0, 0));  // clear wins
        tbl.push_back(mk(1, 4'b0011, 4'b0000, 2'b00, 0, 0, 0, 0, 0,   0, 0, 0, 0, 4'b0111, 0, 1));  // CC

        drive_idle();
        rst_n = 1'b0;
        #12;
        check("reset flags",    {28'd0, flags}, 32'd0);
        check("reset exec_cnt", 32'(exec_cnt),  32'd0);
        check("reset skip_cnt", 32'(skip_cnt),  32'd0);
        check("reset q_flag",   {31'd0, q_flag}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            apply_vec(tbl[i], i);
        end

        // exec counter saturation; skip counter must not move
        for (int i = 0; i < 20; i++) begin
            apply_vec(mk(1, 4'b1110, 4'b0000, 2'b00, 0, 0, 0, 0, 0, 1, 0, 0, 0, 4'b0111,
                         (i + 1 > 15) ? 15 : i + 1, 1), 100 + i);
        end
        // skip counter saturation; exec counter holds at all-ones
        for (int i = 0; i < 16; i++) begin
            apply_vec(mk(1, 4'b1111, 4'b0000, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0111,
                         15, (i + 2 > 15) ? 15 : i + 2), 200 + i);
        end
        apply_vec(mk(1, 4'b1110, 4'b0000, 2'b00, 0, 0, 0, 0, 0, 1, 0, 0, 0, 4'b0111, 15, 15), 300);
        apply_vec(mk(1, 4'b1110, 4'b0000, 2'b00, 0, 0, 0, 0, 1, 1, 0, 0, 0, 4'b0111, 0, 0), 301);
        apply_vec(mk(1, 4'b1110, 4'b1010, 2'b11, 0, 0, 0, 0, 0, 1, 0, 0, 0, 4'b1010, 1, 0), 302);

        // asynchronous reset in the middle of a cycle
        @(negedge clk);
        drive_idle();
        #2;
        rst_n = 1'b0;
        #1;
        check("midreset flags",    {28'd0, flags}, 32'd0);
        check("midreset exec_cnt", 32'(exec_cnt),  32'd0);
        check("midreset cond_ex",  {31'd0, cond_ex}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        apply_vec(mk(1, 4'b1110, 4'b1001, 2'b11, 1, 0, 0, 0, 0, 1, 1, 0, 0, 4'b1001, 1, 0), 400);

`ifdef COND_STICKY_Q_EN
        q_step(1'b1, 2'b01, 4'b0001, 1'b0, 1'b1, "q set");
        q_step(1'b1, 2'b01, 4'b0000, 1'b0, 1'b1, "q sticky");
        q_step(1'b0, 2'b00, 4'b0000, 1'b1, 1'b0, "q clear");
        q_step(1'b1, 2'b10, 4'b0001, 1'b0, 1'b0, "q needs flag_w0");
        q_step(1'b1, 2'b01, 4'b0001, 1'b1, 1'b1, "q set beats clear");
        @(negedge clk);
        drive_idle();
        #2;
        rst_n = 1'b0;
        #1;
        check("q midreset", {31'd0, q_flag}, 32'd0);
        check("q midreset flags", {28'd0, flags}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
`endif

        @(negedge clk);
        drive_idle();
        #1;
        check("idle pc_src", {31'd0, pc_src}, 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
